// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the unified-memory arbiter.
//   SZ_B/SZ_H/SZ_W     - d_size encodings (2'b11 behaves as word)
//   state_t            - arbiter FSM states
//   DEF_MAX_DATA_STREAK - default data-grant streak limit while fetch waits
//   misaligned()       - half at odd address, or word not 4-byte aligned
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int DEF_MAX_DATA_STREAK = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        misaligned = ((size == SZ_H) && a[0]) || (size[1] && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane helper.
//   word        in  32  word read from memory (bytes addr+3..addr)
//   wdata       in  32  right-justified store data
//   size        in   2  access size
//   is_unsigned in   1  zero-extend loads
//   merged      out 32  word with low byte/half replaced by store data
//   rdata       out 32  sign/zero-extended load value
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    always_comb begin
        merged = wdata;
        rdata  = word;
        case (size)
            SZ_B: begin
                merged = {word[31:8], wdata[7:0]};
                rdata  = {{24{~is_unsigned & word[7]}}, word[7:0]};
            end
            SZ_H: begin
                merged = {word[31:16], wdata[15:0]};
                rdata  = {{16{~is_unsigned & word[15]}}, word[15:0]};
            end
            default: begin
                merged = wdata;
                rdata  = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read, word-write memory between
// instruction fetch (if_*) and load/store (d_*). Grants are combinational
// in IDLE; responses (rvalid/rdata) are registered, one cycle later.
// Sub-word stores are a read (grant cycle) followed by a write (RMW_WR).
// Data wins arbitration until MAX_DATA_STREAK consecutive data grants have
// been made while fetch waited; then fetch wins once.
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr/if_gnt          fetch request/accept
//   if_rvalid/if_rdata             fetch response
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata/d_gnt  data request/accept
//   d_rvalid/d_rdata/d_err         data response
//   mem_address/mem_dataIn/mem_wEn/mem_memOut          memory interface
// Optional: define MEM_ARB_ALIGN_CHECK_EN to reject misaligned half/word
// data accesses (granted, no memory access, d_err with d_rvalid).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_wEn,
    input  logic [31:0] mem_memOut
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    state_t        state, state_nxt;
    logic [SW-1:0] streak;
    logic [31:0]   rmw_addr, rmw_data;
    logic [31:0]   merged, ext;
    logic          misal;
    logic          sub_store;

    mem_lane_align u_align (
        .word        (mem_memOut),
        .wdata       (d_wdata),
        .size        (d_size),
        .is_unsigned (d_unsigned),
        .merged      (merged),
        .rdata       (ext)
    );

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic d_err_q;
    assign misal = misaligned(d_size, d_addr[1:0]);
    always_ff @(posedge clk) begin
        if (rst)
            d_err_q <= 1'b0;
        else
            d_err_q <= d_gnt & misal;
    end
    assign d_err = d_err_q;
`else
    assign misal = 1'b0;
    assign d_err = 1'b0;
`endif

    // Byte/half store that actually touches memory needs the write cycle.
    assign sub_store = d_gnt & d_we & ~d_size[1] & ~misal;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sub_store) state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: grants and memory drive; everything is held low in reset
    // so no write can slip through an aborted RMW.
    always_comb begin
        d_gnt       = 1'b0;
        if_gnt      = 1'b0;
        mem_address = 32'h0;
        mem_dataIn  = 32'h0;
        mem_wEn     = 1'b0;
        if (!rst) begin
            if (state == RMW_WR) begin
                mem_address = rmw_addr;
                mem_dataIn  = rmw_data;
                mem_wEn     = 1'b1;
            end else if (d_req && ((streak < SW'(MAX_DATA_STREAK)) || !if_req)) begin
                d_gnt = 1'b1;
                if (!misal) begin
                    mem_address = d_addr;
                    if (d_we && d_size[1]) begin
                        mem_dataIn = d_wdata;
                        mem_wEn    = 1'b1;
                    end
                end
            end else if (if_req) begin
                if_gnt      = 1'b1;
                mem_address = if_addr;
            end
        end
    end

    // Streak, response and RMW latches
    always_ff @(posedge clk) begin
        if (rst) begin
            streak    <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'h0;
            rmw_addr  <= 32'h0;
            rmw_data  <= 32'h0;
        end else begin
            if (if_gnt || !if_req)
                streak <= '0;
            else if (d_gnt && (streak < SW'(MAX_DATA_STREAK)))
                streak <= streak + SW'(1);

            if_rvalid <= if_gnt;
            if (if_gnt)
                if_rdata <= mem_memOut;

            d_rvalid <= (d_gnt & ~sub_store) | (state == RMW_WR);
            if (d_gnt)
                d_rdata <= (!d_we && !misal) ? ext : 32'h0;
            else if (state == RMW_WR)
                d_rdata <= 32'h0;

            if (sub_store) begin
                rmw_addr <= d_addr;
                rmw_data <= merged;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized bench for mem_arbiter, with a byte
// array standing in for memory and a separate golden byte array updated
// from the store rules.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_unsigned;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_address, mem_dataIn, mem_memOut;
    logic        mem_wEn;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem  [256];
    logic [7:0] gold [256];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_wEn(mem_wEn), .mem_memOut(mem_memOut)
    );

    // Memory stand-in: combinational read, little-endian word write.
    logic [7:0] ma;
    assign ma = mem_address[7:0];
    assign mem_memOut = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    always @(posedge clk) begin
        if (mem_wEn) begin
            mem[ma]         <= mem_dataIn[7:0];
            mem[ma + 8'd1]  <= mem_dataIn[15:8];
            mem[ma + 8'd2]  <= mem_dataIn[23:16];
            mem[ma + 8'd3]  <= mem_dataIn[31:24];
        end
    end

    function automatic logic [31:0] gword(input logic [7:0] a);
        return {gold[a + 8'd3], gold[a + 8'd2], gold[a + 8'd1], gold[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the grant cycle, or after a bounded wait.
    task automatic wait_gnt(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt : if_gnt) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        chk(is_d ? "d_gnt_wait" : "if_gnt_wait", 32'(is_d ? d_gnt : if_gnt), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        bit ok;
        logic [31:0] exp;
        if_req = 1'b1; if_addr = addr;
        wait_gnt(1'b0, ok);
        exp = gword(addr[7:0]);
        if (ok) chk("f_addr", mem_address, addr);
        @(posedge clk); #1;
        if_req = 1'b0;
        if (!ok) return;
        @(negedge clk);
        chk("if_rvalid", 32'(if_rvalid), 32'd1);
        chk("if_rdata", if_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic do_data(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit ok;
        bit mis;
        int n;
        logic [31:0] raw, exp_rd, exp_wr;
        logic [7:0] a;
        a = addr[7:0];
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
        d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
        d_addr = addr; d_wdata = wdata;
        wait_gnt(1'b1, ok);
        if (!ok) begin d_req = 1'b0; return; end

        // Expected results from the golden byte image.
        raw = gword(a);
        exp_rd = 32'h0;
        if (!we && !mis) begin
            if (n == 1)      exp_rd = uns ? 32'(raw[7:0])  : 32'($signed(raw[7:0]));
            else if (n == 2) exp_rd = uns ? 32'(raw[15:0]) : 32'($signed(raw[15:0]));
            else             exp_rd = raw;
        end
        if (we && !mis)
            for (int k = 0; k < n; k++) gold[a + 8'(k)] = wdata[8*k +: 8];
        exp_wr = gword(a);

        if (we && n == 4 && !mis) begin
            chk("ws_wen", 32'(mem_wEn), 32'd1);
            chk("ws_data", mem_dataIn, wdata);
            chk("ws_addr", mem_address, addr);
        end else begin
            chk("g_wen", 32'(mem_wEn), 32'd0);
        end
        @(posedge clk); #1;
        d_req = 1'b0;

        if (we && n < 4 && !mis) begin
            // Write cycle: a waiting fetch must not be granted here.
            if_req = 1'b1; if_addr = 32'h10;
            @(negedge clk);
            chk("rmw_wen", 32'(mem_wEn), 32'd1);
            chk("rmw_data", mem_dataIn, exp_wr);
            chk("rmw_addr", mem_address, addr);
            chk("rmw_nogrant", 32'(if_gnt), 32'd0);
            chk("rmw_norv", 32'(d_rvalid), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rmw_fgnt", 32'(if_gnt), 32'd1);
            chk("d_rvalid", 32'(d_rvalid), 32'd1);
            chk("d_rdata", d_rdata, 32'h0);
            chk("d_err", 32'(d_err), 32'd0);
            @(posedge clk); #1;
            if_req = 1'b0;
            @(negedge clk);
            chk("rmw_if_rdata", if_rdata, gword(8'h10));
            @(posedge clk); #1;
            return;
        end

        @(negedge clk);
        chk("d_rvalid", 32'(d_rvalid), 32'd1);
        chk("d_rdata", d_rdata, exp_rd);
        chk("d_err", 32'(d_err), 32'(mis));
        if (mis) chk("mis_wen", 32'(mem_wEn), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] ra;
        for (int i = 0; i < 256; i++) begin
            gold[i] = 8'($urandom);
            mem[i]  = gold[i];
        end
        // Directed memory contents.
        gold[8'h10] = 8'h13; gold[8'h11] = 8'h05; gold[8'h12] = 8'h20; gold[8'h13] = 8'h00;
        gold[8'h21] = 8'h44; gold[8'h22] = 8'h33; gold[8'h23] = 8'h22; gold[8'h24] = 8'h11;
        gold[8'h30] = 8'h80;
        for (int i = 0; i < 256; i++) mem[i] = gold[i];

        // Reset with both requesters active: nothing may be granted.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0;
        d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_dgnt", 32'(d_gnt), 32'd0);
        chk("rst_ignt", 32'(if_gnt), 32'd0);
        chk("rst_wen", 32'(mem_wEn), 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_irv", 32'(if_rvalid), 32'd0);
        chk("rst_drv", 32'(d_rvalid), 32'd0);
        chk("rst_drdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // Fetch only.
        do_fetch(32'h10);
        chk("fetch_const", if_rdata, 32'h00200513);

        // Byte store with RMW.
        do_data(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AB);
        chk("bstore_mem", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]}, 32'h112233AB);

        // Signed / unsigned byte loads of 0x80.
        do_data(1'b0, 2'd0, 1'b0, 32'h30, 32'h0);
        chk("lb_const", d_rdata, 32'hFFFFFF80);
        do_data(1'b0, 2'd0, 1'b1, 32'h30, 32'h0);
        chk("lbu_const", d_rdata, 32'h00000080);

        // Contention: D,D,D,D,I repeating.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cont_d", 32'(d_gnt), 32'(i % 5 != 4));
            chk("cont_i", 32'(if_gnt), 32'(i % 5 == 4));
            @(posedge clk); #1;
        end
        d_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;

        // Word store to 0x22: rejected only with the alignment check.
        do_data(1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEBABE);

        // Reset during the RMW write cycle.
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h50; d_wdata = 32'h77;
        wait_gnt(1'b1, ok);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("mr_wen", 32'(mem_wEn), 32'd0);
        chk("mr_drv", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_drv2", 32'(d_rvalid), 32'd0);
        chk("mr_wen2", 32'(mem_wEn), 32'd0);
        chk("mr_addr", mem_address, 32'h0);
        chk("mr_drdata", d_rdata, 32'h0);
        chk("mr_derr", 32'(d_err), 32'd0);
        chk("mr_irv", 32'(if_rvalid), 32'd0);
        chk("mr_mem", 32'(mem[8'h50]), 32'(gold[8'h50]));
        @(posedge clk); #1;

        // Randomized mix of fetches, loads and stores.
        for (int i = 0; i < 60; i++) begin
            ra = 32'($urandom_range(0, 250));
            if ($urandom_range(0, 4) == 0)
                do_fetch(ra);
            else
                do_data(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
        end

        for (int i = 0; i < 256; i++)
            chk("mem_final", 32'(mem[i]), 32'(gold[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the instruction-fetch requester and the load/store requester.
- Arbitrates between the two, then sequences each access onto the memory's combinational-read, word-write interface.
- Sub-word stores are performed as read-modify-write; loads are sign- or zero-extended.
- Sits between the core's fetch/LSU and the memory instance.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch is waiting; after that, fetch is forced to win.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetched word
- d_req  in  1  data request; fields held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- d_unsigned  in  1  load zero-extend (lbu/lhu)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid or store complete, one-cycle pulse
- d_rdata  out  32  extended load data; 0 for stores
- d_err  out  1  misalignment error, qualified by d_rvalid; only active with the optional feature
- mem_address  out  32  to memory address
- mem_dataIn  out  32  to memory write data
- mem_wEn  out  1  to memory write enable
- mem_memOut  in  32  from memory, combinational read of bytes addr+3..addr

Behaviour:
- Reset values: state = IDLE, streak = 0, and every output = 0. mem_wEn is gated by !rst, so no write ever occurs in a reset cycle.
- FSM states are IDLE and RMW_WR.
- IDLE, arbitration (grants are combinational in IDLE):
  - If d_req is high and (streak < MAX_DATA_STREAK or !if_req): d_gnt = 1.
  - Else if if_req: if_gnt = 1.
  - At most one grant per cycle.
- streak counter:
  - Increments on a d_gnt while if_req is high, saturating at MAX_DATA_STREAK.
  - Clears on if_gnt, or on any cycle where if_req is low.
- Granted fetch or load:
  - mem_address = request address in the grant cycle.
  - mem_memOut is captured into the response register.
  - rvalid pulses in the next cycle (latency 1).
  - Load extension:
    - byte: {24{sign}, [7:0]}
    - half: {16{sign}, [15:0]}
    - word: unchanged
    - sign = 0 when d_unsigned = 1.
- Granted word store: mem_wEn = 1 in the grant cycle with mem_dataIn = d_wdata; d_rvalid pulses the next cycle; state stays IDLE.
- Granted byte/half store:
  - Grant cycle: read the word at d_addr, merge the low byte/half of d_wdata into bits [7:0]/[15:0], latch the merged word and address, then go to RMW_WR.
  - RMW_WR: mem_wEn = 1 with the latched address and data; no grant is issued; d_rvalid pulses the next cycle; return to IDLE.
- Throughput:
  - Back-to-back grants are allowed every cycle in IDLE.
  - A sub-word store occupies 2 cycles.
  - A response pulse may coincide with the next grant.
- Addresses pass through unmodified; the memory handles unaligned access.
- A request deasserted before its grant is dropped with no side effects.
- Reset during RMW_WR aborts the write, and memory is left unchanged. Responses pending at reset are discarded (no rvalid).

Optional Feature:
- Macro MEM_ARB_ALIGN_CHECK_EN.
- When defined:
  - A data request is misaligned when it is a half access with d_addr[0] = 1, or a word access with d_addr[1:0] != 0.
  - A misaligned request is granted normally but performs no memory access (mem_wEn stays 0).
  - The next cycle, d_rvalid = 1, d_err = 1 and d_rdata = 0.
  - Fetch alignment is not checked.
- When undefined: d_err is tied 0 and misaligned accesses proceed as normal.

Decomposition:
- Package mem_arb_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W
  - the state enum (IDLE, RMW_WR)
  - the default streak limit
- One combinational sub-module, mem_lane_align, does the store merge (old word, wdata, size → new word) and the load extend (word, size, unsigned → rdata).

Test Plan:
- Fetch only: if_addr = 0x10 with mem[0x10..0x13] = 13 05 20 00 → if_gnt in cycle 0; cycle 1: if_rvalid = 1, if_rdata = 0x00200513.
- Byte store: d_addr = 0x21, d_size = 00, d_wdata = 0x000000AB, old word at 0x21 = 0x11223344 → mem_wEn only in cycle 1 with mem_dataIn = 0x112233AB; d_rvalid in cycle 2; no grant in cycle 1.
- Signed/unsigned byte loads from a memory byte of 0x80: lb → d_rdata = 0xFFFFFF80; lbu → 0x00000080.
- Contention: d_req and if_req both held high for 10 cycles with word loads → grant pattern D, D, D, D, I, D, D, D, D, I.
- Reset mid-RMW: assert rst in the RMW_WR cycle → mem_wEn = 0, memory unchanged, no d_rvalid, all outputs 0 the next cycle.
- MEM_ARB_ALIGN_CHECK_EN: word store to 0x22 → d_gnt, mem_wEn never asserted, next cycle d_rvalid = 1 and d_err = 1; without the macro the store writes at 0x22 and d_err = 0.
